// File: rtl/ra_sample_sequencer.sv
// Rolling-average control front end: synchronizes the external sample strobe,
// captures each sample and steps it through shift, calculation start and completion,
// while tracking window fill and dropped strobes.
module ra_sample_sequencer #(
   parameter int unsigned RA_SIZE       = 8,
   parameter int unsigned BITS_PER_ELEM = 5,
   parameter int unsigned SYNC_STAGES   = 2,
   localparam int unsigned CntW         = $clog2(RA_SIZE + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_data_clk,
   input  logic [BITS_PER_ELEM-1:0] i_value,
   input  logic                     i_calc_done,
   input  logic                     i_clr_overrun,
   output logic                     o_shift_en,
   output logic [BITS_PER_ELEM-1:0] o_shift_data,
   output logic                     o_start_calc,
   output logic [CntW-1:0]          o_fill_count,
   output logic                     o_warm,
   output logic                     o_avg_valid,
   output logic                     o_overrun,
   output logic                     o_busy
);

   localparam logic [CntW-1:0] FullCnt = CntW'(RA_SIZE);

   typedef enum logic [1:0] {StIdle, StShift, StCalc, StWait} state_e;

   logic [SYNC_STAGES-1:0]   sync_q;
   logic [SYNC_STAGES-1:0]   prime_q;
   logic                     hist_q;
   logic                     armed_q;
   logic                     edge_q;
   logic                     sync_out;

   state_e                   state_q;
   logic                     shift_en_q;
   logic [BITS_PER_ELEM-1:0] shift_data_q;
   logic                     start_calc_q;
   logic [CntW-1:0]          fill_q;
   logic [CntW-1:0]          fill_d;
   logic                     warm_q;
   logic                     avg_valid_q;
   logic                     overrun_q;
   logic                     busy_q;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Synchronizer, history and arming; prime_q marks when sync_out reflects a real sample
   // so that a strobe held high across reset release never looks like a fresh rise.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q  <= '0;
         prime_q <= '0;
         hist_q  <= 1'b0;
         armed_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], i_data_clk};
         prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
         hist_q  <= sync_out;
         armed_q <= armed_q | (prime_q[SYNC_STAGES-1] & ~sync_out);
         edge_q  <= sync_out & ~hist_q & armed_q;
      end
   end

   // Saturating fill increment used when a sample is accepted.
   always_comb begin
      fill_d = fill_q;
      if (fill_q != FullCnt) begin
         fill_d = fill_q + 1'b1;
      end
   end

   // Sequencing FSM; every output is registered alongside the state it belongs to.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         shift_en_q   <= 1'b0;
         shift_data_q <= '0;
         start_calc_q <= 1'b0;
         fill_q       <= '0;
         warm_q       <= 1'b0;
         avg_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         shift_en_q   <= 1'b0;
         start_calc_q <= 1'b0;
         avg_valid_q  <= 1'b0;

         // A drop in the same cycle as a clear must still be reported.
         if (edge_q && (state_q != StIdle)) begin
            overrun_q <= 1'b1;
         end else if (i_clr_overrun) begin
            overrun_q <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (edge_q) begin
                  state_q      <= StShift;
                  shift_data_q <= i_value;
                  shift_en_q   <= 1'b1;
                  fill_q       <= fill_d;
                  warm_q       <= (fill_d == FullCnt);
                  busy_q       <= 1'b1;
               end
            end
            StShift: begin
               state_q      <= StCalc;
               start_calc_q <= 1'b1;
            end
            StCalc: begin
               state_q <= StWait;
            end
            StWait: begin
               if (i_calc_done) begin
                  state_q     <= StIdle;
                  busy_q      <= 1'b0;
                  avg_valid_q <= (fill_q == FullCnt);
               end
            end
         endcase
      end
   end

   assign o_shift_en   = shift_en_q;
   assign o_shift_data = shift_data_q;
   assign o_start_calc = start_calc_q;
   assign o_fill_count = fill_q;
   assign o_warm       = warm_q;
   assign o_avg_valid  = avg_valid_q;
   assign o_overrun    = overrun_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_ra_sample_sequencer.sv
// Directed bench for ra_sample_sequencer: a cycle table for one full sample, plus
// hand-written sequences for warm-up, overrun, clear collision and mid-sequence reset.
module tb_ra_sample_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_data_clk;
   logic [4:0] i_value;
   logic       i_calc_done;
   logic       i_clr_overrun;
   logic       o_shift_en;
   logic [4:0] o_shift_data;
   logic       o_start_calc;
   logic [3:0] o_fill_count;
   logic       o_warm;
   logic       o_avg_valid;
   logic       o_overrun;
   logic       o_busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic auto_done;
   logic [1:0] sc_hist;

   ra_sample_sequencer #(
      .RA_SIZE       (8),
      .BITS_PER_ELEM (5),
      .SYNC_STAGES   (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_data_clk    (i_data_clk),
      .i_value       (i_value),
      .i_calc_done   (i_calc_done),
      .i_clr_overrun (i_clr_overrun),
      .o_shift_en    (o_shift_en),
      .o_shift_data  (o_shift_data),
      .o_start_calc  (o_start_calc),
      .o_fill_count  (o_fill_count),
      .o_warm        (o_warm),
      .o_avg_valid   (o_avg_valid),
      .o_overrun     (o_overrun),
      .o_busy        (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        strb;
      logic [4:0]  val;
      logic        done;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [15:0] pk(input logic sen, input logic sc, input logic [4:0] data,
                                      input logic [3:0] fill, input logic warm, input logic av,
                                      input logic ovr, input logic busy);
      return {sen, sc, data, fill, warm, av, ovr, busy};
   endfunction

   function automatic logic [15:0] outs();
      return pk(o_shift_en, o_start_calc, o_shift_data, o_fill_count, o_warm, o_avg_valid,
                o_overrun, o_busy);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      i_data_clk = 1'b0;
      i_calc_done = 1'b0;
      i_clr_overrun = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      repeat (6) step();
   endtask

   // One strobe of the given period: high for 4 cycles, low for the rest. When auto_done
   // is set, i_calc_done answers one cycle after the o_start_calc cycle.
   task automatic run_strobe(input logic [4:0] v, input int cycles,
                             output int n_shift, output int n_avg);
      n_shift = 0;
      n_avg = 0;
      sc_hist = 2'b00;
      for (int c = 0; c < cycles; c++) begin
         i_data_clk = (c < 4);
         i_value = v;
         i_calc_done = auto_done & sc_hist[1];
         step();
         sc_hist = {sc_hist[0], o_start_calc};
         if (o_shift_en) n_shift++;
         if (o_avg_valid) n_avg++;
      end
      i_data_clk = 1'b0;
      i_calc_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int ns, na, cnt, found;

      // One sample, cycle by cycle; edge 0 is the first one sampling the strobe high.
      for (int i = 0; i < 8; i++) begin
         vecs[i].strb = (i < 5);
         vecs[i].val  = (i < 4) ? 5'd19 : 5'd7;
         vecs[i].done = (i == 6);
      end
      vecs[0].exp = pk(0, 0, 0, 0, 0, 0, 0, 0);
      vecs[1].exp = pk(0, 0, 0, 0, 0, 0, 0, 0);
      vecs[2].exp = pk(0, 0, 0, 0, 0, 0, 0, 0);
      vecs[3].exp = pk(1, 0, 19, 1, 0, 0, 0, 1);
      vecs[4].exp = pk(0, 1, 19, 1, 0, 0, 0, 1);
      vecs[5].exp = pk(0, 0, 19, 1, 0, 0, 0, 1);
      vecs[6].exp = pk(0, 0, 19, 1, 0, 0, 0, 0);
      vecs[7].exp = pk(0, 0, 19, 1, 0, 0, 0, 0);

      auto_done = 1'b1;
      sc_hist = 2'b00;

      // Reset with strobe held high, then keep it high: no sample may be taken.
      rst = 1'b0;
      i_data_clk = 1'b1;
      i_value = 5'd0;
      i_calc_done = 1'b0;
      i_clr_overrun = 1'b0;
      repeat (3) step();
      chk("reset_outputs", int'(outs()), 0);
      rst = 1'b1;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (o_shift_en) cnt++;
      end
      chk("held_high_no_shift", cnt, 0);
      chk("held_high_fill", int'(o_fill_count), 0);
      chk("held_high_overrun", int'(o_overrun), 0);
      i_data_clk = 1'b0;
      repeat (8) step();

      // Table-driven single sample, value 19.
      for (int i = 0; i < 8; i++) begin
         i_data_clk = vecs[i].strb;
         i_value = vecs[i].val;
         i_calc_done = vecs[i].done;
         step();
         chk($sformatf("vec[%0d]", i), int'(outs()), int'(vecs[i].exp));
      end
      i_calc_done = 1'b0;

      // Ten samples 1..10 at a 12-cycle period.
      do_reset();
      for (int s = 1; s <= 10; s++) begin
         run_strobe(5'(s), 12, ns, na);
         chk($sformatf("s%0d_shift_count", s), ns, 1);
         chk($sformatf("s%0d_data", s), int'(o_shift_data), s);
         chk($sformatf("s%0d_fill", s), int'(o_fill_count), (s < 8) ? s : 8);
         chk($sformatf("s%0d_warm", s), int'(o_warm), (s >= 8) ? 1 : 0);
         chk($sformatf("s%0d_avg_valid", s), na, (s >= 8) ? 1 : 0);
      end
      chk("multi_no_overrun", int'(o_overrun), 0);

      // Averager stalls; a second strobe during WAIT is dropped.
      auto_done = 1'b0;
      run_strobe(5'd21, 12, ns, na);
      chk("stall_first_shift", ns, 1);
      chk("stall_busy", int'(o_busy), 1);
      run_strobe(5'd9, 12, ns, na);
      chk("drop_no_shift", ns, 0);
      chk("drop_overrun", int'(o_overrun), 1);
      chk("drop_data_kept", int'(o_shift_data), 21);
      i_calc_done = 1'b1;
      step();
      i_calc_done = 1'b0;
      step();
      chk("stall_released_busy", int'(o_busy), 0);
      chk("overrun_sticky", int'(o_overrun), 1);
      i_clr_overrun = 1'b1;
      step();
      i_clr_overrun = 1'b0;
      chk("overrun_cleared", int'(o_overrun), 0);

      // Clear arriving in the same cycle as a drop: set wins.
      run_strobe(5'd3, 12, ns, na);
      chk("collide_pre_overrun", int'(o_overrun), 0);
      i_data_clk = 1'b1;
      i_value = 5'd4;
      step();
      step();
      step();
      i_clr_overrun = 1'b1;
      step();
      i_clr_overrun = 1'b0;
      chk("collide_overrun_set", int'(o_overrun), 1);
      i_data_clk = 1'b0;
      repeat (5) step();
      i_calc_done = 1'b1;
      step();
      i_calc_done = 1'b0;
      step();
      chk("collide_data_kept", int'(o_shift_data), 3);

      // Reset landing on the CALC cycle, then a late i_calc_done, then a fresh sample.
      found = 0;
      for (int c = 0; c < 20; c++) begin
         i_data_clk = (c < 4);
         i_value = 5'd12;
         step();
         if (o_start_calc) begin
            found = 1;
            break;
         end
      end
      chk("calc_reached", found, 1);
      rst = 1'b0;
      i_data_clk = 1'b0;
      step();
      chk("reset_in_calc_outputs", int'(outs()), 0);
      step();
      step();
      chk("reset_held_outputs", int'(outs()), 0);
      rst = 1'b1;
      i_calc_done = 1'b1;
      step();
      i_calc_done = 1'b0;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (o_shift_en || o_start_calc || o_busy) cnt++;
      end
      chk("late_done_ignored", cnt, 0);
      auto_done = 1'b1;
      run_strobe(5'd17, 12, ns, na);
      chk("post_reset_shift", ns, 1);
      chk("post_reset_fill", int'(o_fill_count), 1);
      chk("post_reset_data", int'(o_shift_data), 17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
